cntr_arb: RTL and testbench

CNTR_ARB -- requirements
Module: cntr_arb

---
 rtl/cntr_arb.sv | 177 +++++++++++++++++
 tb/tb_cntr_arb.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cntr_arb.sv
// Purpose: round-robin arbiter that picks one of BANKS bank-scheduler requests into a single output register.
// Latency: 1 cycle from accept (valid_i & ready) to valid_o.
// Backpressure: ready is all-zero while the output register is full and out_ready is low.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   valid_i/t_i [BANKS]        per-bank request valid and type (1 read, 0 write)
//   dq_i, idx_i, ra_i, ca_i    per-bank fields, packed bank-major (bank b at [b*W +: W])
//   ready [BANKS]              zero or one-hot accept back to the bank schedulers
//   out_ready                  downstream command stage consumes the output register
//   valid_o, dq_o, idx_o, ra_o, ca_o, t_o, bank_o   registered winning request
//
// Build option: define CNTR_ARB_BURST_LOCK_EN to keep granting the same bank
// while it stays on the same row and type, up to BURST_MAX grants in a row.

module cntr_arb #(
    parameter int BANKS     = 4,
    parameter int DQ        = 16,
    parameter int IDX       = 7,
    parameter int RA        = 16,
    parameter int CA        = 10,
    parameter int BURST_MAX = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BANKS-1:0]           valid_i,
    input  logic [BANKS*DQ-1:0]        dq_i,
    input  logic [BANKS*IDX-1:0]       idx_i,
    input  logic [BANKS*RA-1:0]        ra_i,
    input  logic [BANKS*CA-1:0]        ca_i,
    input  logic [BANKS-1:0]           t_i,
    output logic [BANKS-1:0]           ready,
    input  logic                       out_ready,
    output logic                       valid_o,
    output logic [DQ-1:0]              dq_o,
    output logic [IDX-1:0]             idx_o,
    output logic [RA-1:0]              ra_o,
    output logic [CA-1:0]              ca_o,
    output logic                       t_o,
    output logic [$clog2(BANKS)-1:0]   bank_o
);

    localparam int BW = $clog2(BANKS);

    // Unpacked views of the per-bank fields
    logic [DQ-1:0]  w_dq  [BANKS];
    logic [IDX-1:0] w_idx [BANKS];
    logic [RA-1:0]  w_ra  [BANKS];
    logic [CA-1:0]  w_ca  [BANKS];

    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            w_dq[b]  = dq_i[b*DQ +: DQ];
            w_idx[b] = idx_i[b*IDX +: IDX];
            w_ra[b]  = ra_i[b*RA +: RA];
            w_ca[b]  = ca_i[b*CA +: CA];
        end
    end

    // State
    logic [BW-1:0]  r_last_grant;
    logic           r_valid;
    logic [DQ-1:0]  r_dq;
    logic [IDX-1:0] r_idx;
    logic [RA-1:0]  r_ra;
    logic [CA-1:0]  r_ca;
    logic           r_t;
    logic [BW-1:0]  r_bank;

    // Round-robin search starting just after the last granted bank
    logic [BW-1:0]  w_rr_win;
    logic [BW-1:0]  w_cand;
    logic           w_rr_any;
    int             w_pos;

    always_comb begin
        w_rr_win = '0;
        w_rr_any = 1'b0;
        w_cand   = '0;
        w_pos    = 0;
        for (int k = 1; k <= BANKS; k++) begin
            w_pos  = (int'(r_last_grant) + k) % BANKS;
            w_cand = BW'(w_pos);
            if (!w_rr_any && valid_i[w_cand]) begin
                w_rr_any = 1'b1;
                w_rr_win = w_cand;
            end
        end
    end

    logic [BW-1:0] w_win;
    logic          w_hit;

`ifdef CNTR_ARB_BURST_LOCK_EN
    logic [3:0]    r_burst_cnt;
    logic [RA-1:0] r_last_row;
    logic          r_last_t;
    logic          w_lock;

    // A zero burst count means nothing has been granted since reset, so
    // there is no row to stick to yet.
    assign w_lock = (r_burst_cnt != 4'd0)
                 && (r_burst_cnt < 4'(BURST_MAX))
                 && valid_i[r_last_grant]
                 && (w_ra[r_last_grant] == r_last_row)
                 && (t_i[r_last_grant] == r_last_t);

    assign w_win = w_lock ? r_last_grant : w_rr_win;
    assign w_hit = w_lock | w_rr_any;
`else
    assign w_win = w_rr_win;
    assign w_hit = w_rr_any;
`endif

    // Register can take a new request when empty or being drained this cycle
    logic w_can_load;
    logic w_xfer;

    assign w_can_load = ~r_valid | out_ready;
    assign w_xfer     = rst_n & w_hit & w_can_load;

    always_comb begin
        ready = '0;
        if (w_xfer) begin
            ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= BW'(BANKS - 1);
            r_valid      <= 1'b0;
            r_dq         <= '0;
            r_idx        <= '0;
            r_ra         <= '0;
            r_ca         <= '0;
            r_t          <= 1'b0;
            r_bank       <= '0;
        end else if (w_xfer) begin
            r_last_grant <= w_win;
            r_valid      <= 1'b1;
            r_dq         <= w_dq[w_win];
            r_idx        <= w_idx[w_win];
            r_ra         <= w_ra[w_win];
            r_ca         <= w_ca[w_win];
            r_t          <= t_i[w_win];
            r_bank       <= w_win;
        end else if (out_ready) begin
            r_valid      <= 1'b0;
        end
    end

`ifdef CNTR_ARB_BURST_LOCK_EN
    // Burst count restarts at 1 on every grant that is not a lock
    // continuation, including a round-robin grant back to the same bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burst_cnt <= 4'd0;
            r_last_row  <= '0;
            r_last_t    <= 1'b0;
        end else if (w_xfer) begin
            r_burst_cnt <= w_lock ? (r_burst_cnt + 4'd1) : 4'd1;
            r_last_row  <= w_ra[w_win];
            r_last_t    <= t_i[w_win];
        end
    end
`endif

    assign valid_o = r_valid;
    assign dq_o    = r_dq;
    assign idx_o   = r_idx;
    assign ra_o    = r_ra;
    assign ca_o    = r_ca;
    assign t_o     = r_t;
    assign bank_o  = r_bank;

endmodule

// File: tb/tb_cntr_arb.sv
// Bench for cntr_arb: directed scenarios plus random traffic, checked against a
// behavioural model of the arbitration rules (round-robin, optional burst lock).
module tb_cntr_arb;

    localparam int BANKS     = 4;
    localparam int DQ        = 16;
    localparam int IDX       = 7;
    localparam int RA        = 16;
    localparam int CA        = 10;
    localparam int BURST_MAX = 4;
    localparam int BW        = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [BANKS-1:0]      valid_i = '0;
    logic [BANKS-1:0]      t_i = '0;
    logic                  out_ready = 1'b0;
    logic [DQ-1:0]         dq_a  [BANKS];
    logic [IDX-1:0]        idx_a [BANKS];
    logic [RA-1:0]         ra_a  [BANKS];
    logic [CA-1:0]         ca_a  [BANKS];
    logic [BANKS*DQ-1:0]   dq_i;
    logic [BANKS*IDX-1:0]  idx_i;
    logic [BANKS*RA-1:0]   ra_i;
    logic [BANKS*CA-1:0]   ca_i;

    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            dq_i[b*DQ +: DQ]    = dq_a[b];
            idx_i[b*IDX +: IDX] = idx_a[b];
            ra_i[b*RA +: RA]    = ra_a[b];
            ca_i[b*CA +: CA]    = ca_a[b];
        end
    end

    logic [BANKS-1:0] ready;
    logic             valid_o;
    logic [DQ-1:0]    dq_o;
    logic [IDX-1:0]   idx_o;
    logic [RA-1:0]    ra_o;
    logic [CA-1:0]    ca_o;
    logic             t_o;
    logic [BW-1:0]    bank_o;

    cntr_arb #(
        .BANKS(BANKS), .DQ(DQ), .IDX(IDX), .RA(RA), .CA(CA), .BURST_MAX(BURST_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .dq_i(dq_i), .idx_i(idx_i),
        .ra_i(ra_i), .ca_i(ca_i), .t_i(t_i), .ready(ready), .out_ready(out_ready),
        .valid_o(valid_o), .dq_o(dq_o), .idx_o(idx_o), .ra_o(ra_o), .ca_o(ca_o),
        .t_o(t_o), .bank_o(bank_o)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: what the output register should hold and who was
    // granted last, plus the burst bookkeeping.
    int             m_last;
    bit             m_v;
    logic [DQ-1:0]  m_dq;
    logic [IDX-1:0] m_idx;
    logic [RA-1:0]  m_ra;
    logic [CA-1:0]  m_ca;
    logic           m_t;
    int             m_bank;
    int             m_cnt;
    logic [RA-1:0]  m_row;
    logic           m_rt;
    int             xfers;
    logic [BANKS-1:0] obs_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = BANKS - 1; m_v = 1'b0;
        m_dq = '0; m_idx = '0; m_ra = '0; m_ca = '0; m_t = 1'b0; m_bank = 0;
        m_cnt = 0; m_row = '0; m_rt = 1'b0;
    endtask

    task automatic pick(output int w, output bit lk);
        int c;
        w  = -1;
        lk = 1'b0;
`ifdef CNTR_ARB_BURST_LOCK_EN
        if (m_cnt > 0 && m_cnt < BURST_MAX && valid_i[m_last] &&
            ra_a[m_last] == m_row && t_i[m_last] == m_rt) begin
            w  = m_last;
            lk = 1'b1;
        end
`endif
        for (int k = 1; k <= BANKS; k++) begin
            c = (m_last + k) % BANKS;
            if (w < 0 && valid_i[c]) w = c;
        end
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        int w;
        bit lk;
        logic [BANKS-1:0] er;
        @(negedge clk);
        pick(w, lk);
        er = '0;
        if (rst_n && w >= 0 && (!m_v || out_ready)) er[w] = 1'b1;
        chk("ready", ready, er);
        chk("valid_o", valid_o, m_v);
        if (m_v) begin
            chk("dq_o", dq_o, m_dq);
            chk("idx_o", idx_o, m_idx);
            chk("ra_o", ra_o, m_ra);
            chk("ca_o", ca_o, m_ca);
            chk("t_o", t_o, m_t);
            chk("bank_o", bank_o, m_bank);
        end
        obs_q.push_back(ready);
        if (er != '0) begin
            m_v = 1'b1; m_dq = dq_a[w]; m_idx = idx_a[w]; m_ra = ra_a[w];
            m_ca = ca_a[w]; m_t = t_i[w]; m_bank = w;
            m_cnt = lk ? m_cnt + 1 : 1;
            m_row = ra_a[w]; m_rt = t_i[w];
            m_last = w;
            xfers++;
        end else if (rst_n && out_ready) begin
            m_v = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_i = '1;
        out_ready = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_bank_o", bank_o, 0);
        chk("rst_dq_o", dq_o, 0);
        chk("rst_ra_o", ra_o, 0);
        @(posedge clk);
        #1;
        valid_i = '0;
        rst_n = 1'b1;
    endtask

    task automatic rand_fields();
        for (int b = 0; b < BANKS; b++) begin
            dq_a[b]  = DQ'($urandom);
            idx_a[b] = IDX'($urandom);
            ca_a[b]  = CA'($urandom);
        end
    endtask

    logic [BANKS-1:0] e024 [5];
    logic [BANKS-1:0] e027 [6];

    initial begin
        e024 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        e027 = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010};
        for (int b = 0; b < BANKS; b++) begin
            dq_a[b] = '0; idx_a[b] = '0; ra_a[b] = '0; ca_a[b] = '0;
        end
        xfers = 0;
        #2;
        do_reset();

        // All banks valid, drained every cycle: plain rotation starting at bank 0.
        // Rows change every step so a burst lock never holds.
        valid_i = 4'b1111; out_ready = 1'b1;
        obs_q.delete();
        for (int s = 0; s < 5; s++) begin
            rand_fields();
            for (int b = 0; b < BANKS; b++) ra_a[b] = RA'(s*8 + b + 1);
            cycle();
        end
        for (int k = 0; k < 5; k++) chk($sformatf("rot_seq%0d", k), obs_q[k], e024[k]);
        valid_i = '0;
        cycle();

        // Only bank 2, output stalled for 3 cycles, then drained.
        do_reset();
        rand_fields();
        valid_i = 4'b0100; out_ready = 1'b0;
        obs_q.delete();
        for (int s = 0; s < 4; s++) cycle();
        chk("stall_first", obs_q[0], 4'b0100);
        for (int k = 1; k < 4; k++) chk($sformatf("stall_hold%0d", k), obs_q[k], 4'b0000);
        chk("stall_vo", valid_o, 1);
        out_ready = 1'b1; valid_i = '0;
        cycle();
        cycle();
        chk("drain_vo", valid_o, 0);

        // Two banks, continuous drain: a transfer every cycle, no bubble.
        do_reset();
        valid_i = 4'b0011; out_ready = 1'b1;
        xfers = 0;
        for (int s = 0; s < 6; s++) begin
            rand_fields();
            cycle();
        end
        chk("nobubble_xfers", xfers, 6);
        chk("nobubble_vo", valid_o, 1);
        valid_i = '0;
        cycle();

`ifdef CNTR_ARB_BURST_LOCK_EN
        // Bank 1 sticks to row 0x12 until the burst cap, bank 3 keeps switching rows.
        do_reset();
        valid_i = 4'b1010; out_ready = 1'b1; t_i = '0;
        ra_a[1] = 16'h12;
        obs_q.delete();
        for (int s = 0; s < 6; s++) begin
            rand_fields();
            ra_a[3] = RA'(16'h100 + s);
            cycle();
        end
        for (int k = 0; k < 6; k++) chk($sformatf("burst_seq%0d", k), obs_q[k], e027[k]);
        valid_i = '0;
        cycle();
`endif

        // Row change on bank 0 breaks any lock; bank 2 is next.
        do_reset();
        valid_i = 4'b0101; out_ready = 1'b1; t_i = '0;
        obs_q.delete();
        rand_fields();
        ra_a[0] = 16'h5; ra_a[2] = 16'h77;
        cycle();
        ra_a[0] = 16'h6;
        cycle();
        chk("rowchg_0", obs_q[0], 4'b0001);
        chk("rowchg_1", obs_q[1], 4'b0100);
        valid_i = '0;
        cycle();

        // Reset while the register is full: cleared at once, bank 0 first afterwards.
        valid_i = 4'b1100; out_ready = 1'b0;
        rand_fields();
        cycle();
        chk("pre_rst_vo", valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_vo", valid_o, 0);
        chk("async_rst_ready", ready, 0);
        do_reset();
        valid_i = 4'b1111; out_ready = 1'b1;
        obs_q.delete();
        for (int b = 0; b < BANKS; b++) ra_a[b] = RA'(16'h200 + b);
        cycle();
        chk("post_rst_first", obs_q[0], 4'b0001);

        // Random traffic; rows drawn from a small set so bursts do form.
        for (int s = 0; s < 400; s++) begin
            rand_fields();
            valid_i   = BANKS'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            for (int b = 0; b < BANKS; b++) begin
                ra_a[b] = ($urandom_range(0, 3) == 0) ? 16'h34 : 16'h12;
                t_i[b]  = ($urandom_range(0, 7) == 0);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
